ro_pair_meas_ctrl: RTL and testbench

//  Sequences one shared edge counter (rising-edge counter on osc_in, active-high clear) across NUM_RO ring oscillators.
//  Per challenge (idx_a, idx_b): select A, settle, count over a fixed window, capture; repeat for B.

---
 rtl/ro_puf_pkg.sv | 26 ++
 rtl/ro_pair_meas_ctrl_if.sv | 38 +++
 rtl/ro_pair_meas_ctrl_phase_timer.sv | 34 +++
 rtl/ro_pair_meas_ctrl.sv | 174 +++++++++++++++++
 tb/tb_ro_pair_meas_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ro_puf_pkg.sv
// Shared types and constants for the RO-PUF measurement path.
// The RO array and the external edge counter use the same widths.
package ro_puf_pkg;

  localparam int RO_NUM         = 8;
  localparam int RO_SEL_W       = 3;
  localparam int RO_CNT_W       = 8;
  localparam int SETTLE_CYC_DEF = 4;
  localparam int WINDOW_CYC_DEF = 200;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETTLE_A = 3'd1,
    ST_MEAS_A   = 3'd2,
    ST_CAP_A    = 3'd3,
    ST_SETTLE_B = 3'd4,
    ST_MEAS_B   = 3'd5,
    ST_CAP_B    = 3'd6,
    ST_DONE     = 3'd7
  } ro_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ro_pair_meas_ctrl_if.sv
// Challenge/response and RO-mux/counter signals of the pair measurement controller.
interface ro_pair_meas_ctrl_if
  import ro_puf_pkg::*;
#(
  parameter int SEL_W = RO_SEL_W,
  parameter int CNT_W = RO_CNT_W
) ();

  // Handshake: start is a one-cycle request taken only while busy is low and
  // abort is low; the result fields are valid during the single-cycle done
  // pulse and hold until the next accepted start.
  logic             start;
  logic             abort;
  logic [SEL_W-1:0] idx_a;
  logic [SEL_W-1:0] idx_b;
  logic [SEL_W-1:0] osc_sel;
  logic             osc_en;
  logic             cnt_clr;
  logic [CNT_W-1:0] cnt_in;
  logic             busy;
  logic             done;
  logic             response;
  logic             tie;
  logic             err;
  logic [CNT_W-1:0] count_a;
  logic [CNT_W-1:0] count_b;

  modport slave (
    input  start, abort, idx_a, idx_b, cnt_in,
    output osc_sel, osc_en, cnt_clr, busy, done, response, tie, err, count_a, count_b
  );

  modport master (
    output start, abort, idx_a, idx_b, cnt_in,
    input  osc_sel, osc_en, cnt_clr, busy, done, response, tie, err, count_a, count_b
  );

endinterface

// File: rtl/ro_pair_meas_ctrl_phase_timer.sv
// Phase down-counter: loaded on entry to a phase with (length-1),
// reports expiry while it sits at zero.
module phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/ro_pair_meas_ctrl.sv
// Sequences one shared edge counter over two ring oscillators per challenge
// and returns the comparison bit plus both raw counts.
module ro_pair_meas_ctrl
  import ro_puf_pkg::*;
#(
  parameter int NUM_RO     = RO_NUM,
  parameter int SEL_W      = RO_SEL_W,
  parameter int CNT_W      = RO_CNT_W,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int WINDOW_CYC = WINDOW_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  ro_pair_meas_ctrl_if.slave bus,
  output ro_state_e         state_o
);

  localparam int               TMR_W     = $clog2(max_int(SETTLE_CYC, WINDOW_CYC) + 1);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] WINDOW_LD = TMR_W'(WINDOW_CYC - 1);
  localparam logic [SEL_W:0]   NUM_RO_L  = (SEL_W + 1)'(NUM_RO);

  ro_state_e        state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] idx_b_q, idx_b_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
  logic             resp_q, resp_d;
  logic             tie_q, tie_d;
  logic             err_q, err_d;

  logic             accept;
  logic             illegal;
  logic             abort_hit;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_expired;

  assign accept    = (state_q == ST_IDLE) && bus.start && !bus.abort;
  assign abort_hit = (state_q != ST_IDLE) && bus.abort;
  assign illegal   = (bus.idx_a == bus.idx_b)
                  || ({1'b0, bus.idx_a} >= NUM_RO_L)
                  || ({1'b0, bus.idx_b} >= NUM_RO_L);

  phase_timer #(.W(TMR_W)) u_phase_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_expired)
  );

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (illegal) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_SETTLE_A;
            tmr_load = 1'b1;
            tmr_val  = SETTLE_LD;
          end
        end
      end
      ST_SETTLE_A: begin
        if (tmr_expired) begin
          state_d  = ST_MEAS_A;
          tmr_load = 1'b1;
          tmr_val  = WINDOW_LD;
        end
      end
      ST_MEAS_A: if (tmr_expired) state_d = ST_CAP_A;
      ST_CAP_A: begin
        state_d  = ST_SETTLE_B;
        tmr_load = 1'b1;
        tmr_val  = SETTLE_LD;
      end
      ST_SETTLE_B: begin
        if (tmr_expired) begin
          state_d  = ST_MEAS_B;
          tmr_load = 1'b1;
          tmr_val  = WINDOW_LD;
        end
      end
      ST_MEAS_B: if (tmr_expired) state_d = ST_CAP_B;
      ST_CAP_B:  state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (abort_hit) begin
      state_d  = ST_IDLE;
      tmr_load = 1'b0;
    end
  end

  // Result registers: cleared on accept or abort, filled in the capture cycles.
  always_comb begin
    sel_d   = sel_q;
    idx_b_d = idx_b_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    resp_d  = resp_q;
    tie_d   = tie_q;
    err_d   = err_q;
    if (abort_hit) begin
      cnt_a_d = '0;
      cnt_b_d = '0;
      resp_d  = 1'b0;
      tie_d   = 1'b0;
      err_d   = 1'b0;
    end else begin
      if (accept) begin
        cnt_a_d = '0;
        cnt_b_d = '0;
        resp_d  = 1'b0;
        tie_d   = 1'b0;
        err_d   = illegal;
        idx_b_d = bus.idx_b;
        if (!illegal) sel_d = bus.idx_a;
      end
      if (state_q == ST_CAP_A) begin
        cnt_a_d = bus.cnt_in;
        sel_d   = idx_b_q;
      end
      if (state_q == ST_CAP_B) begin
        cnt_b_d = bus.cnt_in;
        resp_d  = (cnt_a_q > bus.cnt_in);
        tie_d   = (cnt_a_q == bus.cnt_in);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      idx_b_q <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      resp_q  <= 1'b0;
      tie_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      idx_b_q <= idx_b_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      resp_q  <= resp_d;
      tie_q   <= tie_d;
      err_q   <= err_d;
    end
  end

  // The counter clears whenever it is not inside a window or its capture cycle.
  assign bus.osc_en   = (state_q == ST_SETTLE_A) || (state_q == ST_MEAS_A)
                     || (state_q == ST_SETTLE_B) || (state_q == ST_MEAS_B);
  assign bus.cnt_clr  = !((state_q == ST_MEAS_A) || (state_q == ST_CAP_A)
                       || (state_q == ST_MEAS_B) || (state_q == ST_CAP_B));
  assign bus.osc_sel  = sel_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.response = resp_q;
  assign bus.tie      = tie_q;
  assign bus.err      = err_q;
  assign bus.count_a  = cnt_a_q;
  assign bus.count_b  = cnt_b_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_ro_pair_meas_ctrl.sv
// Bench for ro_pair_meas_ctrl: behavioural RO array and edge counter,
// expected-result queue checked by a done-driven monitor.
module tb_ro_pair_meas_ctrl;
  import ro_puf_pkg::*;

  localparam int SETTLE = 4;
  localparam int WINDOW = 16;
  localparam int NRO    = 8;
  localparam int LAT    = 2 * (SETTLE + WINDOW + 1) + 1;
  localparam int P [NRO] = '{3, 2, 2, 6, 2, 4, 7, 3};

  typedef struct packed {
    logic [31:0] start_cyc;
    logic [2:0]  a;
    logic [2:0]  b;
    logic [7:0]  ca;
    logic [7:0]  cb;
    logic        resp;
    logic        tie;
    logic        err;
    logic [7:0]  lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic trk_bad  = 1'b0;
  int   trk_off  = 0;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ro_pair_meas_ctrl_if #(.SEL_W(3), .CNT_W(8)) bus  ();
  ro_pair_meas_ctrl_if #(.SEL_W(4), .CNT_W(8)) bus4 ();
  ro_state_e st, st4;

  ro_pair_meas_ctrl #(.NUM_RO(NRO), .SEL_W(3), .CNT_W(8), .SETTLE_CYC(SETTLE), .WINDOW_CYC(WINDOW))
    u_dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave), .state_o(st));

  ro_pair_meas_ctrl #(.NUM_RO(NRO), .SEL_W(4), .CNT_W(8), .SETTLE_CYC(SETTLE), .WINDOW_CYC(WINDOW))
    u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave), .state_o(st4));

  // ---------------- RO array and edge counter models ----------------
  int   div [NRO] = '{default: 0};
  logic ro  [NRO] = '{default: 1'b0};
  logic osc_in;
  logic osc_q = 1'b0;
  logic [7:0] cnt_q = '0;

  always @(negedge clk) begin
    for (int k = 0; k < NRO; k++) begin
      if (div[k] == P[k] - 1) begin
        div[k] <= 0;
        ro[k]  <= ~ro[k];
      end else begin
        div[k] <= div[k] + 1;
      end
    end
  end

  assign osc_in = bus.osc_en & ro[bus.osc_sel];

  always @(posedge clk) begin
    osc_q <= osc_in;
    if (bus.cnt_clr)          cnt_q <= '0;
    else if (osc_in && !osc_q) cnt_q <= cnt_q + 8'd1;
  end

  assign bus.cnt_in  = cnt_q;
  assign bus4.cnt_in = '0;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_only(input logic [2:0] a, input logic [2:0] b, output int s);
    @(posedge clk);
    #1;
    s = cyc;
    bus.idx_a = a;
    bus.idx_b = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic issue(input logic [2:0] a, input logic [2:0] b, input logic [7:0] ca,
                       input logic [7:0] cb, input logic err, input logic extra);
    exp_t ne;
    int   s;
    @(posedge clk);
    #1;
    s            = cyc;
    ne.start_cyc = 32'(s);
    ne.a         = a;
    ne.b         = b;
    ne.ca        = err ? 8'd0 : ca;
    ne.cb        = err ? 8'd0 : cb;
    ne.resp      = !err && (ca > cb);
    ne.tie       = !err && (ca == cb);
    ne.err       = err;
    ne.lat       = err ? 8'd1 : 8'(LAT);
    exp_q.push_back(ne);
    bus.idx_a = a;
    bus.idx_b = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("start_clears_count_a", bus.count_a, 0);
    if (extra) begin
      wait_until(s + 10);
      bus.idx_a = 3'd6;
      bus.idx_b = 3'd7;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_until(s + LAT);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(negedge clk);
      chk("start_in_done_ignored_busy", bus.busy, 0);
    end
    wait_drain();
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t       me;
    int         off;
    logic       en_x, clr_x, busy_x;
    logic [2:0] sel_x;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (exp_q.size() > 0) begin
          me     = exp_q[0];
          off    = cyc - int'(me.start_cyc);
          en_x   = !me.err && ((off >= 1 && off <= SETTLE + WINDOW)
                   || (off >= SETTLE + WINDOW + 2 && off <= 2 * (SETTLE + WINDOW) + 1));
          clr_x  = me.err || !((off >= SETTLE + 1 && off <= SETTLE + WINDOW + 1)
                   || (off >= 2 * SETTLE + WINDOW + 2 && off <= 2 * (SETTLE + WINDOW) + 2));
          busy_x = (off >= 1) && (off <= int'(me.lat));
          sel_x  = (off <= SETTLE + WINDOW + 1) ? me.a : me.b;
          if (bus.osc_en !== en_x || bus.cnt_clr !== clr_x || bus.busy !== busy_x
              || (en_x && bus.osc_sel !== sel_x)) begin
            if (!trk_bad) trk_off = off;
            trk_bad = 1'b1;
          end
          if (bus.done) begin
            void'(exp_q.pop_front());
            chk("done_latency", off, 32'(me.lat));
            chk("count_a",  bus.count_a,  32'(me.ca));
            chk("count_b",  bus.count_b,  32'(me.cb));
            chk("response", bus.response, 32'(me.resp));
            chk("tie",      bus.tie,      32'(me.tie));
            chk("err",      bus.err,      32'(me.err));
            if (trk_bad) $display("first phase-trace deviation at cycle offset %0d", trk_off);
            chk("phase_trace_ok", !trk_bad, 1);
            trk_bad = 1'b0;
          end
        end else if (bus.done) begin
          chk("unexpected_done", bus.done, 0);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int s;
    bus.start  = 1'b0; bus.abort  = 1'b0; bus.idx_a  = '0; bus.idx_b  = '0;
    bus4.start = 1'b0; bus4.abort = 1'b0; bus4.idx_a = '0; bus4.idx_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cnt_clr", bus.cnt_clr, 1);
    chk("rst_osc_en",  bus.osc_en,  0);
    chk("rst_busy",    bus.busy,    0);
    chk("rst_done",    bus.done,    0);
    chk("rst_osc_sel", bus.osc_sel, 0);
    chk("rst_state",   32'(st),     32'(ST_IDLE));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: challenge (2,5), then held outputs
    issue(3'd2, 3'd5, 8'd4, 8'd2, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("hold_count_a",  bus.count_a,  4);
    chk("hold_response", bus.response, 1);
    chk("hold_done_low", bus.done,     0);

    // 2: swapped challenge
    issue(3'd5, 3'd2, 8'd2, 8'd4, 1'b0, 1'b0);

    // 3: illegal challenges
    issue(3'd3, 3'd3, 8'd0, 8'd0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    bus4.idx_a = 4'd9;
    bus4.idx_b = 4'd2;
    bus4.start = 1'b1;
    @(negedge clk);
    chk("ill9_pre_osc_en", bus4.osc_en, 0);
    @(posedge clk);
    #1;
    bus4.start = 1'b0;
    @(negedge clk);
    chk("ill9_done",    bus4.done,    1);
    chk("ill9_err",     bus4.err,     1);
    chk("ill9_count_a", bus4.count_a, 0);
    chk("ill9_count_b", bus4.count_b, 0);
    chk("ill9_osc_en",  bus4.osc_en,  0);
    @(negedge clk);
    chk("ill9_done_once", bus4.done, 0);
    chk("ill9_err_held",  bus4.err,  1);

    // abort and start together in IDLE
    @(posedge clk);
    #1;
    bus.idx_a = 3'd2; bus.idx_b = 3'd5;
    bus.start = 1'b1; bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    @(negedge clk);
    chk("abort_start_idle_busy", bus.busy, 0);

    // 4: abort on cycle 10 of MEAS_B
    start_only(3'd2, 3'd5, s);
    wait_until(s + 2 * SETTLE + WINDOW + 11);
    bus.abort = 1'b1;
    @(negedge clk);
    chk("abort_pre_osc_en",  bus.osc_en,  1);
    chk("abort_pre_osc_sel", bus.osc_sel, 5);
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    @(negedge clk);
    chk("abort_busy",    bus.busy,    0);
    chk("abort_cnt_clr", bus.cnt_clr, 1);
    chk("abort_osc_en",  bus.osc_en,  0);
    chk("abort_count_a", bus.count_a, 0);
    chk("abort_done",    bus.done,    0);
    repeat (50) @(posedge clk);
    issue(3'd2, 3'd5, 8'd4, 8'd2, 1'b0, 1'b0);

    // 5: reset during MEAS_A
    start_only(3'd2, 3'd5, s);
    wait_until(s + 10);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy",    bus.busy,    0);
    chk("rstmid_osc_en",  bus.osc_en,  0);
    chk("rstmid_cnt_clr", bus.cnt_clr, 1);
    chk("rstmid_osc_sel", bus.osc_sel, 0);
    chk("rstmid_done",    bus.done,    0);
    chk("rstmid_state",   32'(st),     32'(ST_IDLE));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(3'd5, 3'd2, 8'd2, 8'd4, 1'b0, 1'b0);

    // 6: equal periods with extra starts while busy and in DONE
    issue(3'd1, 3'd4, 8'd4, 8'd4, 1'b0, 1'b1);
    repeat (60) @(posedge clk);
    @(negedge clk);
    chk("final_idle_busy", bus.busy, 0);
    chk("final_tie_held",  bus.tie,  1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
